hazard_fwd_unit: RTL and testbench
==================================

Name: hazard_fwd_unit

Overview:
- Parametrised pipeline hazard and forwarding controller for the 16-bit pipelined core.
- Generalises the single-stage ALU-to-Rs/Rt forwarding in the decoder to FWD_DEPTH tracked stages.
- Adds load-use stall insertion, a taken-branch/jump flush sequencer and a saturating stall-cycle counter.
- Sits beside the decoder in ID. Drives the forwarding-mux selects, PC/IF-ID hold and the ID/EX bubble insert.

Parameters:
- RSIZE, 4: register address width.
- FWD_DEPTH, 3: number of downstream stages tracked (EX, MEM, WB); range 1..7.
- LOAD_LAT, 1: stages after EX before load data can be forwarded; range 0..FWD_DEPTH-1.
- BR_FLUSH, 2: bubbles inserted after a taken branch/jump; range 1..15.
- CNT_W, 16: stall counter width.

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid  in  1  ID holds a real instruction.
- id_rs  in  RSIZE  source register 1.
- id_rt  in  RSIZE  source register 2.
- id_use_rs  in  1  instruction reads Rs.
- id_use_rt  in  1  instruction reads Rt.
- id_wr_en  in  1  instruction writes the register file.
- id_wr_addr  in  RSIZE  destination register.
- id_is_load  in  1  instruction is LW.
- ex_br_taken  in  1  EX resolved a taken B/JAL/JR this cycle.
- fwd_rs_sel  out  3  0 = register file; k = forward from tracked stage k-1 (1 = EX).
- fwd_rt_sel  out  3  same encoding as fwd_rs_sel, for Rt.
- stall  out  1  hold PC and IF/ID.
- bubble  out  1  ID/EX loads a NOP.
- flush  out  1  squash IF/ID.
- stall_cnt  out  CNT_W  cycles spent stalled or flushing; saturating.

Behaviour:
History shift register:
- Entries h[0..FWD_DEPTH-1], each {valid, addr, is_load}. h[0] is the instruction in EX.
- Every clk: h[k+1] <= h[k].
- h[0] <= {id_valid & id_wr_en & ~bubble, id_wr_addr, id_is_load}. A bubble always pushes valid=0.

Forwarding (combinational):
- fwd_rs_sel = 1 + (smallest k) such that h[k].valid, h[k].addr == id_rs, id_rs != 0 and id_use_rs.
- If no entry matches, fwd_rs_sel = 0. Youngest match wins.
- fwd_rt_sel follows the same rule using id_rt and id_use_rt.

Load-use hazard:
- luh = 1 when some k < LOAD_LAT has h[k].valid & h[k].is_load and its addr matches a used, nonzero id_rs or id_rt.
- With LOAD_LAT = 0, luh is always 0.
- luh is evaluated only in RUN.

FSM:
- States: RUN, FLUSH. Counter fcnt, 4 bits.
- RUN:
  - If ex_br_taken: flush=1, bubble=1, stall=0, fcnt <= BR_FLUSH-1. Go to FLUSH if BR_FLUSH > 1, else stay in RUN.
  - Else if luh: stall=1, bubble=1, stay in RUN. The stall repeats each cycle until luh clears, because bubbles shift the load down.
  - Else all three outputs are 0.
- FLUSH:
  - flush=1, bubble=1, stall=0. fcnt decrements; return to RUN when fcnt == 0.
  - ex_br_taken is ignored in FLUSH, because squashed instructions cannot branch.
- Priority: ex_br_taken beats luh in the same cycle. The stall is dropped because the stalled instruction is wrong-path.

stall_cnt:
- Increments on any cycle where stall | flush.
- Saturates at all-ones and never wraps.

Reset (async assert, sync release):
- All h[k].valid = 0, state RUN, fcnt = 0, stall_cnt = 0.
- All outputs 0: fwd selects 0; stall, bubble, flush 0.
- Assertion mid-FLUSH or mid-stall aborts immediately.

Register 0:
- Never matches, never forwards, never stalls.

Test Plan:
- Forwarding depth: ADD R3 then back-to-back ADD R4,R3,R3 -> fwd_rs_sel=1 and fwd_rt_sel=1. Insert 1 then 2 unrelated instructions -> sel=2, then 3. Insert 3 -> sel=0.
- Youngest wins: ADD R5; ADD R5; SUB R6,R5,R1 -> fwd_rs_sel=1, not 2.
- Load-use: LW R2 then ADD R7,R2,R1 with LOAD_LAT=1 -> exactly 1 cycle of stall=bubble=1, then fwd_rs_sel=2, stall_cnt=1. With LOAD_LAT=2 -> 2 stall cycles, then sel=3.
- Flush: ex_br_taken pulse with BR_FLUSH=2 -> flush=bubble=1 for 2 cycles. A second ex_br_taken in cycle 2 is ignored. stall_cnt=2.
- Branch vs stall collision: luh and ex_br_taken in the same cycle -> stall=0, flush=1. No stall cycles follow.
- Reset and saturation: assert rst_n=0 during the FLUSH second cycle -> all outputs 0 asynchronously, and the first post-reset instruction sees fwd sel 0. With CNT_W=4, force 20 stall cycles -> stall_cnt holds 15.

Source files
------------

// File: rtl/hazard_fwd_unit.sv
// Hazard/forwarding controller beside ID: tracks FWD_DEPTH downstream writers,
// selects forwarding sources, inserts load-use stalls and taken-branch flushes.
module hazard_fwd_unit #(
  parameter int RSIZE     = 4,
  parameter int FWD_DEPTH = 3,
  parameter int LOAD_LAT  = 1,
  parameter int BR_FLUSH  = 2,
  parameter int CNT_W     = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             id_valid,
  input  logic [RSIZE-1:0] id_rs,
  input  logic [RSIZE-1:0] id_rt,
  input  logic             id_use_rs,
  input  logic             id_use_rt,
  input  logic             id_wr_en,
  input  logic [RSIZE-1:0] id_wr_addr,
  input  logic             id_is_load,
  input  logic             ex_br_taken,
  output logic [2:0]       fwd_rs_sel,
  output logic [2:0]       fwd_rt_sel,
  output logic             stall,
  output logic             bubble,
  output logic             flush,
  output logic [CNT_W-1:0] stall_cnt
);

  typedef enum logic {RUN, FLUSH} state_t;
  localparam logic [3:0] FL_INIT = 4'(BR_FLUSH - 1);

  state_t                           state_q, state_d;
  logic [3:0]                       fcnt_q, fcnt_d;
  logic [FWD_DEPTH-1:0]             h_vld_q, h_vld_d, h_ld_q, h_ld_d;
  logic [FWD_DEPTH-1:0][RSIZE-1:0]  h_addr_q, h_addr_d;
  logic [CNT_W-1:0]                 cnt_q, cnt_d;
  logic [FWD_DEPTH-1:0]             rs_hit, rt_hit;
  logic                             luh;
  logic                             stall_i, bubble_i, flush_i;

  // Register 0 is hard-wired zero, so it is excluded from every match.
  for (genvar k = 0; k < FWD_DEPTH; k++) begin : g_hit
    assign rs_hit[k] = h_vld_q[k] && (h_addr_q[k] == id_rs) && (id_rs != '0) && id_use_rs;
    assign rt_hit[k] = h_vld_q[k] && (h_addr_q[k] == id_rt) && (id_rt != '0) && id_use_rt;
  end

  always_comb begin
    fwd_rs_sel = 3'd0;
    fwd_rt_sel = 3'd0;
    luh        = 1'b0;
    // Walk oldest to youngest so the youngest match is the one that sticks.
    for (int k = FWD_DEPTH - 1; k >= 0; k--) begin
      if (rs_hit[k]) fwd_rs_sel = 3'(k + 1);
      if (rt_hit[k]) fwd_rt_sel = 3'(k + 1);
    end
    for (int k = 0; k < FWD_DEPTH; k++)
      if (k < LOAD_LAT && h_ld_q[k] && (rs_hit[k] || rt_hit[k])) luh = 1'b1;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= RUN;
      fcnt_q   <= '0;
      h_vld_q  <= '0;
      h_ld_q   <= '0;
      h_addr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      fcnt_q   <= fcnt_d;
      h_vld_q  <= h_vld_d;
      h_ld_q   <= h_ld_d;
      h_addr_q <= h_addr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      RUN: if (ex_br_taken) begin
        fcnt_d  = FL_INIT;
        state_d = (BR_FLUSH > 1) ? FLUSH : RUN;
      end
      FLUSH: begin
        fcnt_d = fcnt_q - 4'd1;
        if (fcnt_q <= 4'd1) state_d = RUN;
      end
      default: state_d = RUN;
    endcase
  end

  // Outputs are forced low while reset is held, whatever the inputs do.
  always_comb begin
    stall_i  = 1'b0;
    bubble_i = 1'b0;
    flush_i  = 1'b0;
    case (state_q)
      RUN: if (ex_br_taken) begin
        flush_i  = 1'b1;
        bubble_i = 1'b1;
      end else if (luh) begin
        stall_i  = 1'b1;
        bubble_i = 1'b1;
      end
      FLUSH: begin
        flush_i  = 1'b1;
        bubble_i = 1'b1;
      end
      default: ;
    endcase
    stall  = stall_i  & rst_n;
    bubble = bubble_i & rst_n;
    flush  = flush_i  & rst_n;
  end

  always_comb begin
    h_vld_d[0]  = id_valid & id_wr_en & ~bubble;
    h_addr_d[0] = id_wr_addr;
    h_ld_d[0]   = id_is_load;
    for (int k = 1; k < FWD_DEPTH; k++) begin
      h_vld_d[k]  = h_vld_q[k-1];
      h_addr_d[k] = h_addr_q[k-1];
      h_ld_d[k]   = h_ld_q[k-1];
    end
    cnt_d = cnt_q;
    if ((stall | flush) && !(&cnt_q)) cnt_d = cnt_q + 1'b1;
  end

  assign stall_cnt = cnt_q;

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed bench for hazard_fwd_unit: default instance plus a LOAD_LAT=2,
// CNT_W=4 instance sharing the same stimulus.
module tb_hazard_fwd_unit;
  logic       clk = 1'b0;
  logic       rst_n;
  logic       id_valid, id_use_rs, id_use_rt, id_wr_en, id_is_load, ex_br_taken;
  logic [3:0] id_rs, id_rt, id_wr_addr;

  logic [2:0]  a_rs_sel, a_rt_sel, b_rs_sel, b_rt_sel;
  logic        a_stall, a_bubble, a_flush, b_stall, b_bubble, b_flush;
  logic [15:0] a_cnt;
  logic [3:0]  b_cnt;

  int nvec = 0;
  int nerr = 0;

  always #5 clk = ~clk;

  hazard_fwd_unit #(.RSIZE(4), .FWD_DEPTH(3), .LOAD_LAT(1), .BR_FLUSH(2), .CNT_W(16)) u_a (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
    .fwd_rs_sel(a_rs_sel), .fwd_rt_sel(a_rt_sel), .stall(a_stall), .bubble(a_bubble),
    .flush(a_flush), .stall_cnt(a_cnt));

  hazard_fwd_unit #(.RSIZE(4), .FWD_DEPTH(3), .LOAD_LAT(2), .BR_FLUSH(2), .CNT_W(4)) u_b (
    .clk(clk), .rst_n(rst_n), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_wr_en(id_wr_en),
    .id_wr_addr(id_wr_addr), .id_is_load(id_is_load), .ex_br_taken(ex_br_taken),
    .fwd_rs_sel(b_rs_sel), .fwd_rt_sel(b_rt_sel), .stall(b_stall), .bubble(b_bubble),
    .flush(b_flush), .stall_cnt(b_cnt));

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    nvec++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Present one ID-stage instruction for the next cycle, then settle.
  task automatic ins(input logic v, input logic [3:0] rs, input logic [3:0] rt,
                     input logic urs, input logic urt, input logic we,
                     input logic [3:0] wa, input logic ld, input logic br);
    @(negedge clk);
    id_valid = v; id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_wr_en = we; id_wr_addr = wa; id_is_load = ld; ex_br_taken = br;
    #1;
  endtask

  task automatic nop();
    ins(1'b0, 4'd0, 4'd0, 1'b0, 1'b0, 1'b0, 4'd0, 1'b0, 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    #2;
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  initial begin
    rst_n = 1'b0;
    id_valid = 1'b0; id_rs = '0; id_rt = '0; id_use_rs = 1'b0; id_use_rt = 1'b0;
    id_wr_en = 1'b0; id_wr_addr = '0; id_is_load = 1'b0; ex_br_taken = 1'b1;
    #3;
    chk("rst_flush_gated", a_flush, 0);
    chk("rst_bubble",      a_bubble, 0);
    chk("rst_stall",       a_stall, 0);
    chk("rst_rs_sel",      a_rs_sel, 0);
    chk("rst_cnt",         a_cnt, 0);
    ex_br_taken = 1'b0;
    @(negedge clk); @(negedge clk);
    rst_n = 1'b1;

    // forwarding depth
    ins(1, 4'd1, 4'd2, 1, 1, 1, 4'd3, 0, 0);
    chk("fwd_empty", a_rs_sel, 0);
    ins(1, 4'd3, 4'd3, 1, 1, 1, 4'd4, 0, 0);
    chk("fwd_d1_rs", a_rs_sel, 1);
    chk("fwd_d1_rt", a_rt_sel, 1);
    ins(1, 4'd1, 4'd2, 1, 1, 1, 4'd3, 0, 0);
    ins(1, 4'd0, 4'd0, 0, 0, 0, 4'd0, 0, 0);
    ins(1, 4'd3, 4'd3, 1, 1, 1, 4'd4, 0, 0);
    chk("fwd_d2_rs", a_rs_sel, 2);
    chk("fwd_d2_rt", a_rt_sel, 2);
    ins(1, 4'd1, 4'd2, 1, 1, 1, 4'd3, 0, 0);
    nop(); nop();
    ins(1, 4'd3, 4'd3, 1, 1, 1, 4'd4, 0, 0);
    chk("fwd_d3_rs", a_rs_sel, 3);
    ins(1, 4'd1, 4'd2, 1, 1, 1, 4'd3, 0, 0);
    nop(); nop(); nop();
    ins(1, 4'd3, 4'd3, 1, 1, 1, 4'd4, 0, 0);
    chk("fwd_d4_none", a_rs_sel, 0);

    // youngest wins, R0, use gating
    ins(1, 4'd1, 4'd2, 1, 1, 1, 4'd5, 0, 0);
    ins(1, 4'd1, 4'd2, 1, 1, 1, 4'd5, 0, 0);
    ins(1, 4'd5, 4'd1, 1, 1, 1, 4'd6, 0, 0);
    chk("young_rs", a_rs_sel, 1);
    chk("young_rt", a_rt_sel, 0);
    ins(1, 4'd1, 4'd1, 1, 1, 1, 4'd0, 0, 0);
    ins(1, 4'd0, 4'd0, 1, 1, 0, 4'd0, 0, 0);
    chk("r0_rs", a_rs_sel, 0);
    chk("r0_rt", a_rt_sel, 0);
    ins(1, 4'd6, 4'd6, 0, 1, 0, 4'd0, 0, 0);
    chk("use_gate_rs", a_rs_sel, 0);
    chk("use_gate_rt", a_rt_sel, 3);

    // load-use, LOAD_LAT=1
    ins(1, 4'd1, 4'd0, 1, 0, 1, 4'd2, 1, 0);
    chk("lw_nostall", a_stall, 0);
    ins(1, 4'd2, 4'd1, 1, 1, 1, 4'd7, 0, 0);
    chk("luh_stall",  a_stall, 1);
    chk("luh_bubble", a_bubble, 1);
    chk("luh_flush",  a_flush, 0);
    ins(1, 4'd2, 4'd1, 1, 1, 1, 4'd7, 0, 0);
    chk("luh_clear", a_stall, 0);
    chk("luh_sel2",  a_rs_sel, 2);
    chk("luh_cnt",   a_cnt, 1);
    ins(1, 4'd1, 4'd0, 1, 0, 1, 4'd0, 1, 0);
    ins(1, 4'd0, 4'd0, 1, 0, 1, 4'd8, 0, 0);
    chk("lw_r0_nostall", a_stall, 0);

    // flush sequence
    do_reset();
    ins(1, 4'd1, 4'd0, 1, 0, 1, 4'd8, 0, 1);
    chk("fl1_flush",  a_flush, 1);
    chk("fl1_bubble", a_bubble, 1);
    chk("fl1_stall",  a_stall, 0);
    ins(1, 4'd1, 4'd0, 1, 0, 1, 4'd8, 0, 1);
    chk("fl2_flush",  a_flush, 1);
    ins(1, 4'd1, 4'd0, 1, 0, 1, 4'd8, 0, 0);
    chk("fl3_done",   a_flush, 0);
    chk("fl3_bubble", a_bubble, 0);
    chk("fl_cnt",     a_cnt, 2);

    // branch beats load-use
    ins(1, 4'd1, 4'd0, 1, 0, 1, 4'd2, 1, 0);
    ins(1, 4'd2, 4'd1, 1, 1, 1, 4'd7, 0, 1);
    chk("col_stall", a_stall, 0);
    chk("col_flush", a_flush, 1);
    ins(1, 4'd2, 4'd1, 1, 1, 1, 4'd7, 0, 0);
    chk("col2_stall", a_stall, 0);
    chk("col2_flush", a_flush, 1);
    ins(1, 4'd2, 4'd1, 1, 1, 1, 4'd10, 0, 0);
    chk("col3_stall", a_stall, 0);
    chk("col3_flush", a_flush, 0);
    chk("col_cnt",    a_cnt, 4);

    // async reset in the second flush cycle
    ins(1, 4'd1, 4'd0, 1, 0, 0, 4'd0, 0, 1);
    ins(1, 4'd1, 4'd0, 1, 0, 0, 4'd0, 0, 0);
    chk("mid_flush", a_flush, 1);
    rst_n = 1'b0;
    ex_br_taken = 1'b1;
    #1;
    chk("arst_flush",  a_flush, 0);
    chk("arst_bubble", a_bubble, 0);
    chk("arst_stall",  a_stall, 0);
    chk("arst_cnt",    a_cnt, 0);
    ex_br_taken = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    ins(1, 4'd10, 4'd10, 1, 1, 1, 4'd9, 0, 0);
    chk("post_rst_rs", a_rs_sel, 0);
    chk("post_rst_rt", a_rt_sel, 0);

    // LOAD_LAT=2 instance, then saturation
    do_reset();
    ins(1, 4'd1, 4'd0, 1, 0, 1, 4'd2, 1, 0);
    ins(1, 4'd2, 4'd1, 1, 1, 1, 4'd7, 0, 0);
    chk("b_luh1", b_stall, 1);
    ins(1, 4'd2, 4'd1, 1, 1, 1, 4'd7, 0, 0);
    chk("b_luh2", b_stall, 1);
    ins(1, 4'd2, 4'd1, 1, 1, 1, 4'd7, 0, 0);
    chk("b_luh_clear", b_stall, 0);
    chk("b_sel3",      b_rs_sel, 3);
    chk("b_cnt",       b_cnt, 2);
    for (int i = 0; i < 20; i++) ins(1, 4'd1, 4'd0, 1, 0, 0, 4'd0, 0, 1);
    ins(1, 4'd1, 4'd0, 1, 0, 0, 4'd0, 0, 0);
    chk("sat_flush_off", b_flush, 0);
    chk("b_cnt_sat",     b_cnt, 15);
    chk("a_cnt_21",      a_cnt, 21);

    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end
endmodule
